instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers 64-bit instructions in a small FIFO and turns
// them into one-cycle buffer/accumulator strobes or a counted array stream.
`timescale 1ns/1ps
module instr_sequencer #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 32,
   parameter int OBUF_AW    = 4,
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [63:0]        instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic               array_done,
   output logic               inp_buf_we,
   output logic [ADDR_W-1:0]  inp_buf_addr,
   output logic [DATA_W-1:0]  inp_buf_data,
   output logic               wt_buf_we,
   output logic [ADDR_W-1:0]  wt_buf_addr,
   output logic [DATA_W-1:0]  wt_buf_data,
   output logic               stream_en,
   output logic               i_mode,
   output logic               acc_store,
   output logic [OBUF_AW-1:0] acc_addr,
   output logic               obuf_tx,
   output logic [OBUF_AW-1:0] obuf_addr,
   output logic               acc_reset,
   output logic               busy,
   output logic               err_illegal
);

   // Fields are packed MSB-first; 5+ADDR_W+DATA_W+CNT_W must not exceed 64.
   localparam int FIELD_W = 5 + ADDR_W + DATA_W + CNT_W;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int OCC_W   = PTR_W + 1;
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   logic [FIELD_W-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]   occ_q;
   logic               full_s, empty_s, push_s, pop_s;
   logic [FIELD_W-1:0] head_s;
   logic [4:0]         op_s;
   logic [ADDR_W-1:0]  addr_s;
   logic [DATA_W-1:0]  data_s;
   logic [CNT_W-1:0]   len_s;
   logic               unused_instr_s;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic               stream_en_q, stream_en_d;
   logic               i_mode_q, i_mode_d;
   logic               inp_we_q, inp_we_d;
   logic [ADDR_W-1:0]  inp_addr_q, inp_addr_d;
   logic [DATA_W-1:0]  inp_data_q, inp_data_d;
   logic               wt_we_q, wt_we_d;
   logic [ADDR_W-1:0]  wt_addr_q, wt_addr_d;
   logic [DATA_W-1:0]  wt_data_q, wt_data_d;
   logic               acc_store_q, acc_store_d;
   logic [OBUF_AW-1:0] acc_addr_q, acc_addr_d;
   logic               obuf_tx_q, obuf_tx_d;
   logic [OBUF_AW-1:0] obuf_addr_q, obuf_addr_d;
   logic               acc_reset_q, acc_reset_d;
   logic               err_q, err_d;

   assign full_s      = (occ_q == FULL_OCC);
   assign empty_s     = (occ_q == {OCC_W{1'b0}});
   // Ready is forced low while reset is held so nothing is accepted into a flushing FIFO.
   assign instr_ready = rst_n & ~full_s;
   assign push_s      = instr_valid & instr_ready;
   assign pop_s       = (state_q == ST_IDLE) & ~empty_s;
   assign head_s      = fifo_mem_q[rd_ptr_q];
   assign {op_s, addr_s, data_s, len_s} = head_s;
   assign unused_instr_s = ^instr;

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_q[wr_ptr_q] <= instr[63 -: FIELD_W];
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         occ_q    <= {OCC_W{1'b0}};
      end else begin
         if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_s, pop_s})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      i_mode_d    = i_mode_q;
      inp_we_d    = 1'b0;
      inp_addr_d  = inp_addr_q;
      inp_data_d  = inp_data_q;
      wt_we_d     = 1'b0;
      wt_addr_d   = wt_addr_q;
      wt_data_d   = wt_data_q;
      acc_store_d = 1'b0;
      acc_addr_d  = acc_addr_q;
      obuf_tx_d   = 1'b0;
      obuf_addr_d = obuf_addr_q;
      acc_reset_d = 1'b0;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (pop_s) begin
               case (op_s)
                  5'd0, 5'd31: begin
                     state_d = ST_IDLE;
                  end
                  5'd1: begin
                     i_mode_d = 1'b0;
                     len_d    = len_s;
                     state_d  = ST_STREAM;
                  end
                  5'd2: begin
                     i_mode_d = 1'b1;
                     len_d    = len_s;
                     state_d  = ST_STREAM;
                  end
                  5'd3: begin
                     acc_store_d = 1'b1;
                     acc_addr_d  = addr_s[OBUF_AW-1:0];
                  end
                  5'd4: begin
                     inp_we_d   = 1'b1;
                     inp_addr_d = addr_s;
                     inp_data_d = data_s;
                  end
                  5'd5: begin
                     wt_we_d   = 1'b1;
                     wt_addr_d = addr_s;
                     wt_data_d = data_s;
                  end
                  5'd6: begin
                     obuf_tx_d   = 1'b1;
                     obuf_addr_d = addr_s[OBUF_AW-1:0];
                  end
                  5'd7: begin
                     acc_reset_d = 1'b1;
                  end
                  default: begin
                     err_d = 1'b1;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         // len_q counts remaining extra cycles, so a length of N streams N+1 cycles.
         ST_STREAM: begin
            if (len_q == {CNT_W{1'b0}}) begin
               state_d = ST_WAIT;
            end else begin
               len_d = len_q - CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (array_done) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      stream_en_d = (state_d == ST_STREAM);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         len_q       <= {CNT_W{1'b0}};
         stream_en_q <= 1'b0;
         i_mode_q    <= 1'b0;
         inp_we_q    <= 1'b0;
         inp_addr_q  <= {ADDR_W{1'b0}};
         inp_data_q  <= {DATA_W{1'b0}};
         wt_we_q     <= 1'b0;
         wt_addr_q   <= {ADDR_W{1'b0}};
         wt_data_q   <= {DATA_W{1'b0}};
         acc_store_q <= 1'b0;
         acc_addr_q  <= {OBUF_AW{1'b0}};
         obuf_tx_q   <= 1'b0;
         obuf_addr_q <= {OBUF_AW{1'b0}};
         acc_reset_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         stream_en_q <= stream_en_d;
         i_mode_q    <= i_mode_d;
         inp_we_q    <= inp_we_d;
         inp_addr_q  <= inp_addr_d;
         inp_data_q  <= inp_data_d;
         wt_we_q     <= wt_we_d;
         wt_addr_q   <= wt_addr_d;
         wt_data_q   <= wt_data_d;
         acc_store_q <= acc_store_d;
         acc_addr_q  <= acc_addr_d;
         obuf_tx_q   <= obuf_tx_d;
         obuf_addr_q <= obuf_addr_d;
         acc_reset_q <= acc_reset_d;
         err_q       <= err_d;
      end
   end

   assign inp_buf_we   = inp_we_q;
   assign inp_buf_addr = inp_addr_q;
   assign inp_buf_data = inp_data_q;
   assign wt_buf_we    = wt_we_q;
   assign wt_buf_addr  = wt_addr_q;
   assign wt_buf_data  = wt_data_q;
   assign stream_en    = stream_en_q;
   assign i_mode       = i_mode_q;
   assign acc_store    = acc_store_q;
   assign acc_addr     = acc_addr_q;
   assign obuf_tx      = obuf_tx_q;
   assign obuf_addr    = obuf_addr_q;
   assign acc_reset    = acc_reset_q;
   assign err_illegal  = err_q;
   assign busy         = (state_q != ST_IDLE) | ~empty_s;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected strobe events are queued as
// instructions are driven and compared against events captured from the DUT.
`timescale 1ns/1ps
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] instr = 64'd0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic        array_done = 1'b0;
   logic        inp_buf_we, wt_buf_we, stream_en, i_mode, acc_store, obuf_tx, acc_reset, busy, err_illegal;
   logic [14:0] inp_buf_addr, wt_buf_addr;
   logic [31:0] inp_buf_data, wt_buf_data;
   logic [3:0]  acc_addr, obuf_addr;

   instr_sequencer #(.ADDR_W(15), .DATA_W(32), .OBUF_AW(4), .CNT_W(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .array_done(array_done), .inp_buf_we(inp_buf_we), .inp_buf_addr(inp_buf_addr),
      .inp_buf_data(inp_buf_data), .wt_buf_we(wt_buf_we), .wt_buf_addr(wt_buf_addr),
      .wt_buf_data(wt_buf_data), .stream_en(stream_en), .i_mode(i_mode), .acc_store(acc_store),
      .acc_addr(acc_addr), .obuf_tx(obuf_tx), .obuf_addr(obuf_addr), .acc_reset(acc_reset),
      .busy(busy), .err_illegal(err_illegal));

   always #5 clk = ~clk;

   typedef struct { int kind; logic [14:0] addr; logic [31:0] data; int stamp; } ev_t;
   typedef struct { int len; logic mode; bit changed; } run_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   multi_cnt = 0;
   ev_t  exp_q[$];
   ev_t  obs_q[$];
   run_t run_q[$];
   int   cur_run = 0;
   logic cur_mode = 1'b0;
   bit   cur_changed = 1'b0;
   ev_t  mon_e;
   run_t mon_r;

   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor: kinds 1=inp write 2=wt write 3=acc_store 4=obuf_tx 5=acc_reset.
   always @(negedge clk) begin
      mon_e.kind = 0; mon_e.addr = 15'd0; mon_e.data = 32'd0; mon_e.stamp = cyc;
      if ($countones({inp_buf_we, wt_buf_we, acc_store, obuf_tx, acc_reset}) > 1) multi_cnt++;
      if (inp_buf_we) begin mon_e.kind = 1; mon_e.addr = inp_buf_addr; mon_e.data = inp_buf_data; end
      else if (wt_buf_we) begin mon_e.kind = 2; mon_e.addr = wt_buf_addr; mon_e.data = wt_buf_data; end
      else if (acc_store) begin mon_e.kind = 3; mon_e.addr = {11'd0, acc_addr}; end
      else if (obuf_tx) begin mon_e.kind = 4; mon_e.addr = {11'd0, obuf_addr}; end
      else if (acc_reset) mon_e.kind = 5;
      if (mon_e.kind != 0) obs_q.push_back(mon_e);
      if (stream_en) begin
         if (cur_run == 0) begin cur_mode = i_mode; cur_changed = 1'b0; end
         else if (i_mode !== cur_mode) cur_changed = 1'b1;
         cur_run++;
      end else if (cur_run > 0) begin
         mon_r.len = cur_run; mon_r.mode = cur_mode; mon_r.changed = cur_changed;
         run_q.push_back(mon_r);
         cur_run = 0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic expect_ev(input int kind, input logic [14:0] a, input logic [31:0] d, input int stamp);
      ev_t e;
      e.kind = kind; e.addr = a; e.data = d; e.stamp = stamp;
      exp_q.push_back(e);
   endtask

   task automatic push(input logic [4:0] op, input logic [14:0] a, input logic [31:0] d,
                       input logic [7:0] c, output int acc);
      int n = 0;
      instr = {op, a, d, c, 4'h0};
      instr_valid = 1'b1;
      while (!instr_ready && n < 200) begin tick(); n++; end
      total++;
      if (!instr_ready) begin
         bad++;
         $display("FAIL push_timeout: instr_ready=%b want 1", instr_ready);
      end
      @(posedge clk); #1;
      acc = cyc;
      instr_valid = 1'b0;
   endtask

   task automatic pop_pair(output ev_t o, output ev_t x, output bit ok);
      int n = 0;
      ok = 1'b1;
      o.kind = -1; o.addr = 15'd0; o.data = 32'd0; o.stamp = -1;
      x = o;
      while (obs_q.size() == 0 && n < 300) begin tick(); n++; end
      if (exp_q.size() == 0 || obs_q.size() == 0) ok = 1'b0;
      if (exp_q.size() > 0) x = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
   endtask

   task automatic wait_run(output run_t r, output bit ok);
      int n = 0;
      r.len = -1; r.mode = 1'bx; r.changed = 1'b0;
      while (run_q.size() == 0 && n < 600) begin tick(); n++; end
      ok = (run_q.size() > 0);
      if (ok) r = run_q.pop_front();
   endtask

   task automatic pulse_done(output int d);
      array_done = 1'b1;
      tick();
      d = cyc;
      array_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      total++;
      if ({inp_buf_we, wt_buf_we, stream_en, i_mode, acc_store, obuf_tx, acc_reset, busy, err_illegal} !== 9'd0
          || inp_buf_addr !== 15'd0 || inp_buf_data !== 32'd0 || wt_buf_addr !== 15'd0
          || wt_buf_data !== 32'd0 || acc_addr !== 4'd0 || obuf_addr !== 4'd0) begin
         bad++;
         $display("FAIL reset_outputs: some output nonzero (busy=%b err=%b stream_en=%b) want all 0", busy, err_illegal, stream_en);
      end
      total++;
      if (instr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", instr_ready); end
      rst_n = 1'b1;
      tick();
      total++;
      if (instr_ready !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_release: ready=%b busy=%b want 1 0", instr_ready, busy);
      end
   endtask

   task automatic test_single_write();
      int acc; ev_t o, x; bit ok;
      push(5'd4, 15'h0012, 32'hDEADBEEF, 8'd0, acc);
      expect_ev(1, 15'h0012, 32'hDEADBEEF, acc + 1);
      pop_pair(o, x, ok);
      total++;
      if (!ok || o.kind !== x.kind || o.addr !== x.addr || o.data !== x.data || o.stamp !== x.stamp) begin
         bad++;
         $display("FAIL single_write: got k=%0d a=%h d=%h cyc=%0d want k=%0d a=%h d=%h cyc=%0d",
                  o.kind, o.addr, o.data, o.stamp, x.kind, x.addr, x.data, x.stamp);
      end
      tick(); tick();
      total++;
      if (inp_buf_we !== 1'b0 || inp_buf_addr !== 15'h0012 || inp_buf_data !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL write_hold: we=%b a=%h d=%h want 0 0012 deadbeef", inp_buf_we, inp_buf_addr, inp_buf_data);
      end
   endtask

   task automatic test_opcodes();
      int acc; ev_t o, x; bit ok;
      push(5'd3, 15'h01A5, 32'h0, 8'd0, acc);        expect_ev(3, 15'h0005, 32'h0, -1);
      push(5'd6, 15'h7FF7, 32'h0, 8'd0, acc);        expect_ev(4, 15'h0007, 32'h0, -1);
      push(5'd7, 15'h0000, 32'h0, 8'd0, acc);        expect_ev(5, 15'h0000, 32'h0, -1);
      push(5'd0, 15'h1111, 32'h11111111, 8'd0, acc);
      push(5'd31, 15'h2222, 32'h22222222, 8'd0, acc);
      push(5'd5, 15'h7ABC, 32'h01234567, 8'd0, acc); expect_ev(2, 15'h7ABC, 32'h01234567, -1);
      for (int i = 0; i < 4; i++) begin
         pop_pair(o, x, ok);
         total++;
         if (!ok || o.kind !== x.kind || o.addr !== x.addr || o.data !== x.data) begin
            bad++;
            $display("FAIL opcode_ev%0d: got k=%0d a=%h d=%h want k=%0d a=%h d=%h",
                     i, o.kind, o.addr, o.data, x.kind, x.addr, x.data);
         end
      end
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (obs_q.size() != 0 || busy !== 1'b0) begin
         bad++; $display("FAIL opcode_nop: extra events=%0d busy=%b want 0 0", obs_q.size(), busy);
      end
   endtask

   task automatic test_stream();
      int acc, d; ev_t o, x; bit ok; run_t r;
      push(5'd1, 15'h0, 32'h0, 8'd3, acc);
      push(5'd5, 15'h0033, 32'hCAFEF00D, 8'd0, acc);
      wait_run(r, ok);
      total++;
      if (!ok || r.len !== 4 || r.mode !== 1'b0 || r.changed) begin
         bad++; $display("FAIL stream_mac: got len=%0d mode=%b chg=%b want 4 0 0", r.len, r.mode, r.changed);
      end
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (obs_q.size() != 0 || busy !== 1'b1 || stream_en !== 1'b0) begin
         bad++;
         $display("FAIL stream_wait: events=%0d busy=%b stream_en=%b want 0 1 0", obs_q.size(), busy, stream_en);
      end
      pulse_done(d);
      expect_ev(2, 15'h0033, 32'hCAFEF00D, d + 1);
      pop_pair(o, x, ok);
      total++;
      if (!ok || o.kind !== x.kind || o.addr !== x.addr || o.data !== x.data || o.stamp !== x.stamp) begin
         bad++;
         $display("FAIL stream_release: got k=%0d a=%h cyc=%0d want k=%0d a=%h cyc=%0d",
                  o.kind, o.addr, o.stamp, x.kind, x.addr, x.stamp);
      end
   endtask

   task automatic test_cnt0();
      int acc, d; bit ok; run_t r;
      push(5'd2, 15'h0, 32'h0, 8'd0, acc);
      wait_run(r, ok);
      total++;
      if (!ok || r.len !== 1 || r.mode !== 1'b1) begin
         bad++; $display("FAIL cnt0_weights: got len=%0d mode=%b want 1 1", r.len, r.mode);
      end
      pulse_done(d);
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL cnt0_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int acc, d, n; ev_t o, x; bit ok; run_t r;
      push(5'd1, 15'h0, 32'h0, 8'd1, acc);
      wait_run(r, ok);
      total++;
      if (!ok || r.len !== 2 || r.mode !== 1'b0) begin
         bad++; $display("FAIL bp_stream: got len=%0d mode=%b want 2 0", r.len, r.mode);
      end
      for (int i = 1; i <= 4; i++) begin
         push(5'd4, 15'(16'h0100 + i), 32'hA0000000 + i, 8'd0, acc);
         expect_ev(1, 15'(16'h0100 + i), 32'hA0000000 + i, -1);
      end
      total++;
      if (instr_ready !== 1'b0) begin bad++; $display("FAIL bp_full: ready=%b want 0", instr_ready); end
      instr = {5'd4, 15'h0105, 32'hA0000005, 8'd0, 4'h0};
      instr_valid = 1'b1;
      expect_ev(1, 15'h0105, 32'hA0000005, -1);
      tick(); tick(); tick();
      total++;
      if (instr_ready !== 1'b0 || obs_q.size() != 0) begin
         bad++; $display("FAIL bp_hold: ready=%b events=%0d want 0 0", instr_ready, obs_q.size());
      end
      pulse_done(d);
      n = 0;
      while (!instr_ready && n < 50) begin tick(); n++; end
      tick();
      instr_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pop_pair(o, x, ok);
         total++;
         if (!ok || o.kind !== x.kind || o.addr !== x.addr || o.data !== x.data) begin
            bad++;
            $display("FAIL bp_order%0d: got k=%0d a=%h d=%h want k=%0d a=%h d=%h",
                     i, o.kind, o.addr, o.data, x.kind, x.addr, x.data);
         end
      end
   endtask

   task automatic test_simul_push_pop();
      int acc; ev_t o, x; bit ok; run_t r;
      push(5'd1, 15'h0, 32'h0, 8'd0, acc);
      wait_run(r, ok);
      total++;
      if (!ok || r.len !== 1 || r.mode !== 1'b0) begin
         bad++; $display("FAIL spp_stream: got len=%0d mode=%b want 1 0", r.len, r.mode);
      end
      for (int i = 1; i <= 3; i++) begin
         push(5'd3, 15'(i), 32'h0, 8'd0, acc);
         expect_ev(3, 15'(i), 32'h0, -1);
      end
      array_done = 1'b1;
      tick();
      array_done = 1'b0;
      instr = {5'd3, 15'h0004, 32'h0, 8'd0, 4'h0};
      instr_valid = 1'b1;
      expect_ev(3, 15'h0004, 32'h0, -1);
      tick();
      instr_valid = 1'b0;
      total++;
      if (instr_ready !== 1'b1) begin bad++; $display("FAIL spp_ready: ready=%b want 1", instr_ready); end
      for (int i = 0; i < 4; i++) begin
         pop_pair(o, x, ok);
         total++;
         if (!ok || o.kind !== x.kind || o.addr !== x.addr) begin
            bad++;
            $display("FAIL spp_order%0d: got k=%0d a=%h want k=%0d a=%h", i, o.kind, o.addr, x.kind, x.addr);
         end
      end
   endtask

   task automatic test_illegal();
      int acc; ev_t o, x; bit ok;
      push(5'b01010, 15'h0055, 32'h55555555, 8'd9, acc);
      tick(); tick(); tick();
      total++;
      if (err_illegal !== 1'b1 || obs_q.size() != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL illegal_set: err=%b events=%0d busy=%b want 1 0 0", err_illegal, obs_q.size(), busy);
      end
      push(5'd7, 15'h0, 32'h0, 8'd0, acc);
      expect_ev(5, 15'h0, 32'h0, -1);
      pop_pair(o, x, ok);
      total++;
      if (!ok || o.kind !== x.kind) begin bad++; $display("FAIL illegal_next: got k=%0d want k=%0d", o.kind, x.kind); end
      tick();
      total++;
      if (err_illegal !== 1'b1) begin bad++; $display("FAIL illegal_sticky: err=%b want 1", err_illegal); end
   endtask

   task automatic test_reset_mid_stream();
      int acc, n;
      push(5'd2, 15'h0, 32'h0, 8'd255, acc);
      push(5'd7, 15'h0, 32'h0, 8'd0, acc);
      push(5'd7, 15'h0, 32'h0, 8'd0, acc);
      n = 0;
      while (cur_run < 5 && n < 50) begin tick(); n++; end
      array_done = 1'b1;
      tick();
      array_done = 1'b0;
      n = 0;
      while (cur_run < 10 && n < 50) begin tick(); n++; end
      total++;
      if (stream_en !== 1'b1 || i_mode !== 1'b1 || cur_run !== 10) begin
         bad++;
         $display("FAIL midstream_run: stream_en=%b i_mode=%b run=%0d want 1 1 10", stream_en, i_mode, cur_run);
      end
      rst_n = 1'b0;
      tick();
      total++;
      if (stream_en !== 1'b0 || i_mode !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b0 || err_illegal !== 1'b0) begin
         bad++;
         $display("FAIL midstream_reset: stream_en=%b i_mode=%b busy=%b ready=%b err=%b want 0 0 0 0 0",
                  stream_en, i_mode, busy, instr_ready, err_illegal);
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (instr_ready !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL midstream_release: ready=%b busy=%b want 1 0", instr_ready, busy);
      end
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (obs_q.size() != 0 || stream_en !== 1'b0) begin
         bad++; $display("FAIL midstream_flush: events=%0d stream_en=%b want 0 0", obs_q.size(), stream_en);
      end
      run_q.delete();
   endtask

   initial begin
      tick();
      test_reset();
      test_single_write();
      test_opcodes();
      test_stream();
      test_cnt0();
      test_back_to_back();
      test_simul_push_pop();
      test_illegal();
      test_reset_mid_stream();
      total++;
      if (multi_cnt != 0 || exp_q.size() != 0) begin
         bad++; $display("FAIL final: multi_strobe=%0d pending_expected=%0d want 0 0", multi_cnt, exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
